// File: rtl/calpoc_button_player.sv
// Replays a 3-bit A op B command as timed button presses toward the calculator:
// Clear, A[2:0], operator, B[2:0], Equals, with an abort path that issues Clear.
module calpoc_button_player #(
    parameter int unsigned PRESS_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_a,
    input  logic [2:0] cmd_b,
    input  logic       cmd_op,
    input  logic       abort,
    output logic       ButtonFor1,
    output logic       ButtonFor0,
    output logic       ButtonForOR,
    output logic       ButtonForXOR,
    output logic       ButtonForEquals,
    output logic       ButtonForClear,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [3:0] press_index
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        GAP,
        ABORT_GAP,
        ABORT_PRESS,
        ABORT_TAIL
    } state_t;

    localparam logic [7:0] P_LOAD = 8'(PRESS_CYCLES - 1);
    localparam logic [7:0] G_LOAD = 8'(GAP_CYCLES - 1);

    localparam logic [5:0] K_1   = 6'b000001;
    localparam logic [5:0] K_0   = 6'b000010;
    localparam logic [5:0] K_OR  = 6'b000100;
    localparam logic [5:0] K_XOR = 6'b001000;
    localparam logic [5:0] K_EQ  = 6'b010000;
    localparam logic [5:0] K_CLR = 6'b100000;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [3:0] slot, slot_n;
    logic [2:0] a_q, b_q;
    logic       op_q;
    logic [5:0] btn, btn_n, slot_btn;
    logic       done_q, done_n;
    logic       aborted_q, aborted_n;
    logic       accept, last;

    assign accept = (state == IDLE) && cmd_valid;
    assign last   = (cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            slot      <= 4'd0;
            a_q       <= 3'd0;
            b_q       <= 3'd0;
            op_q      <= 1'b0;
            btn       <= 6'd0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            slot      <= slot_n;
            btn       <= btn_n;
            done_q    <= done_n;
            aborted_q <= aborted_n;
            if (accept) begin
                a_q  <= cmd_a;
                b_q  <= cmd_b;
                op_q <= cmd_op;
            end
        end
    end

    // The counter loads duration-1 on entry and leaves a state when it hits 0.
    always_comb begin
        state_n   = state;
        slot_n    = slot;
        cnt_n     = last ? 8'd0 : cnt - 8'd1;
        done_n    = 1'b0;
        aborted_n = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = 8'd0;
                if (cmd_valid) begin
                    state_n = PRESS;
                    cnt_n   = P_LOAD;
                    slot_n  = 4'd0;
                end
            end
            PRESS: begin
                if (abort) begin
                    state_n = ABORT_GAP;
                    cnt_n   = G_LOAD;
                end else if (last) begin
                    state_n = GAP;
                    cnt_n   = G_LOAD;
                end
            end
            GAP: begin
                if (abort) begin
                    state_n = ABORT_GAP;
                    cnt_n   = G_LOAD;
                end else if (last) begin
                    if (slot == 4'd8) begin
                        state_n = IDLE;
                        cnt_n   = 8'd0;
                        slot_n  = 4'd0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = PRESS;
                        cnt_n   = P_LOAD;
                        slot_n  = slot + 4'd1;
                    end
                end
            end
            ABORT_GAP: begin
                if (last) begin
                    state_n = ABORT_PRESS;
                    cnt_n   = P_LOAD;
                end
            end
            ABORT_PRESS: begin
                if (last) begin
                    state_n = ABORT_TAIL;
                    cnt_n   = G_LOAD;
                end
            end
            ABORT_TAIL: begin
                if (last) begin
                    state_n   = IDLE;
                    cnt_n     = 8'd0;
                    slot_n    = 4'd0;
                    aborted_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 8'd0;
                slot_n  = 4'd0;
            end
        endcase
    end

    // Buttons are decoded from the next state so they rise with the state.
    always_comb begin
        slot_btn = 6'd0;
        case (slot_n)
            4'd0:    slot_btn = K_CLR;
            4'd1:    slot_btn = a_q[2] ? K_1 : K_0;
            4'd2:    slot_btn = a_q[1] ? K_1 : K_0;
            4'd3:    slot_btn = a_q[0] ? K_1 : K_0;
            4'd4:    slot_btn = op_q ? K_XOR : K_OR;
            4'd5:    slot_btn = b_q[2] ? K_1 : K_0;
            4'd6:    slot_btn = b_q[1] ? K_1 : K_0;
            4'd7:    slot_btn = b_q[0] ? K_1 : K_0;
            4'd8:    slot_btn = K_EQ;
            default: slot_btn = 6'd0;
        endcase
        btn_n = 6'd0;
        unique case (1'b1)
            (state_n == PRESS):       btn_n = slot_btn;
            (state_n == ABORT_PRESS): btn_n = K_CLR;
            default:                  btn_n = 6'd0;
        endcase
    end

    assign {ButtonForClear, ButtonForEquals, ButtonForXOR,
            ButtonForOR, ButtonFor0, ButtonFor1} = btn;

    assign busy        = (state != IDLE);
    assign cmd_ready   = (state == IDLE);
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign press_index = slot;

endmodule

// File: tb/tb_calpoc_button_player.sv
// Bench for calpoc_button_player: two instances (P=2/G=3 and defaults),
// per-cycle scoreboard of expected outputs fed from a command table.
module tb_calpoc_button_player;

    localparam int P0 = 2;
    localparam int G0 = 3;
    localparam int P1 = 4;
    localparam int G1 = 4;

    localparam logic [2:0] K1   = 3'd0;
    localparam logic [2:0] K0   = 3'd1;
    localparam logic [2:0] KOR  = 3'd2;
    localparam logic [2:0] KXOR = 3'd3;
    localparam logic [2:0] KEQ  = 3'd4;
    localparam logic [2:0] KCLR = 3'd5;

    typedef struct packed {
        logic [5:0] btn;
        logic       busy;
        logic       done;
        logic       abt;
        logic [3:0] idx;
    } obs_t;

    typedef struct packed {
        logic            w;
        logic [2:0]      a;
        logic [2:0]      b;
        logic            op;
        logic [8:0][2:0] seq;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, val0, rdy0, op0, ab0, busy0, done0, abt0;
    logic [2:0] a0, b0;
    logic [5:0] btn0;
    logic [3:0] idx0;
    logic       rst1, val1, rdy1, op1, ab1, busy1, done1, abt1;
    logic [2:0] a1, b1;
    logic [5:0] btn1;
    logic [3:0] idx1;

    calpoc_button_player #(.PRESS_CYCLES(P0), .GAP_CYCLES(G0)) dut0 (
        .clk(clk), .reset(rst0), .cmd_valid(val0), .cmd_ready(rdy0),
        .cmd_a(a0), .cmd_b(b0), .cmd_op(op0), .abort(ab0),
        .ButtonFor1(btn0[0]), .ButtonFor0(btn0[1]), .ButtonForOR(btn0[2]),
        .ButtonForXOR(btn0[3]), .ButtonForEquals(btn0[4]),
        .ButtonForClear(btn0[5]), .busy(busy0), .done(done0),
        .aborted(abt0), .press_index(idx0)
    );

    calpoc_button_player dut1 (
        .clk(clk), .reset(rst1), .cmd_valid(val1), .cmd_ready(rdy1),
        .cmd_a(a1), .cmd_b(b1), .cmd_op(op1), .abort(ab1),
        .ButtonFor1(btn1[0]), .ButtonFor0(btn1[1]), .ButtonForOR(btn1[2]),
        .ButtonForXOR(btn1[3]), .ButtonForEquals(btn1[4]),
        .ButtonForClear(btn1[5]), .busy(busy1), .done(done1),
        .aborted(abt1), .press_index(idx1)
    );

    obs_t q0[$];
    obs_t q1[$];
    int   cmp_n = 0;
    int   bad_n = 0;
    int   bc0 = 0;
    int   bc1 = 0;
    bit   mon_en = 1'b0;
    vec_t tbl[5];

    function automatic obs_t idle_rec(logic d, logic ab);
        obs_t r;
        r.btn = 6'd0; r.busy = 1'b0; r.done = d; r.abt = ab; r.idx = 4'd0;
        return r;
    endfunction

    function automatic obs_t busy_rec(logic [5:0] b, logic [3:0] i);
        obs_t r;
        r.btn = b; r.busy = 1'b1; r.done = 1'b0; r.abt = 1'b0; r.idx = i;
        return r;
    endfunction

    function automatic void push(int w, obs_t r);
        if (w == 0) q0.push_back(r);
        else q1.push_back(r);
    endfunction

    function automatic int qsize(int w);
        return (w == 0) ? q0.size() : q1.size();
    endfunction

    // idx 4'hF marks press_index as don't-care (abort states)
    function automatic void check(string nm, obs_t g, obs_t e);
        cmp_n++;
        if (g.btn !== e.btn || g.busy !== e.busy || g.done !== e.done ||
            g.abt !== e.abt || (e.idx != 4'hF && g.idx !== e.idx)) begin
            bad_n++;
            if (bad_n <= 40)
                $display("FAIL %s t=%0t got btn=%b busy=%b done=%b abt=%b idx=%0d want btn=%b busy=%b done=%b abt=%b idx=%0d",
                         nm, $time, g.btn, g.busy, g.done, g.abt, g.idx,
                         e.btn, e.busy, e.done, e.abt, e.idx);
        end
    endfunction

    function automatic void check_val(string nm, int g, int e);
        cmp_n++;
        if (g != e) begin
            bad_n++;
            if (bad_n <= 40)
                $display("FAIL %s t=%0t got %0d want %0d", nm, $time, g, e);
        end
    endfunction

    function automatic vec_t mk(logic w, logic [2:0] a, logic [2:0] b, logic op,
                                logic [2:0] s0, logic [2:0] s1, logic [2:0] s2,
                                logic [2:0] s3, logic [2:0] s4, logic [2:0] s5,
                                logic [2:0] s6, logic [2:0] s7, logic [2:0] s8);
        vec_t v;
        v.w = w; v.a = a; v.b = b; v.op = op;
        v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2;
        v.seq[3] = s3; v.seq[4] = s4; v.seq[5] = s5;
        v.seq[6] = s6; v.seq[7] = s7; v.seq[8] = s8;
        return v;
    endfunction

    always @(negedge clk) begin : mon
        obs_t g, e;
        if (mon_en) begin
            g = {btn0, busy0, done0, abt0, idx0};
            if (q0.size() > 0) e = q0.pop_front();
            else e = idle_rec(1'b0, 1'b0);
            check("dut0", g, e);
            check_val("onehot0", int'($countones(btn0) <= 1), 1);
            check_val("ready0", int'(rdy0 == !busy0), 1);
            if (busy0) bc0++;
            else begin
                if (done0) check_val("busylen0", bc0, 9 * (P0 + G0));
                bc0 = 0;
            end

            g = {btn1, busy1, done1, abt1, idx1};
            if (q1.size() > 0) e = q1.pop_front();
            else e = idle_rec(1'b0, 1'b0);
            check("dut1", g, e);
            check_val("onehot1", int'($countones(btn1) <= 1), 1);
            check_val("ready1", int'(rdy1 == !busy1), 1);
            if (busy1) bc1++;
            else begin
                if (done1) check_val("busylen1", bc1, 9 * (P1 + G1));
                bc1 = 0;
            end
        end
    end

    task automatic drive(input int w, input logic v, input logic [2:0] a,
                         input logic [2:0] b, input logic op);
        if (w == 0) begin
            val0 = v; a0 = a; b0 = b; op0 = op;
        end else begin
            val1 = v; a1 = a; b1 = b; op1 = op;
        end
    endtask

    // Expected busy cycles 0..nrec-1 of a command, plus the done cycle if fin.
    task automatic push_cmd(input vec_t t, input int nrec, input bit fin);
        int p, per, s, ph;
        logic [5:0] one;
        logic [5:0] b;
        one = 6'd1;
        p   = t.w ? P1 : P0;
        per = t.w ? (P1 + G1) : (P0 + G0);
        for (int k = 0; k < nrec; k++) begin
            s  = k / per;
            ph = k % per;
            b  = (ph < p) ? (one << t.seq[s]) : 6'd0;
            push(int'(t.w), busy_rec(b, 4'(s)));
        end
        if (fin) push(int'(t.w), idle_rec(1'b1, 1'b0));
    endtask

    task automatic push_abort(input int w);
        int p, g;
        p = (w != 0) ? P1 : P0;
        g = (w != 0) ? G1 : G0;
        for (int k = 0; k < g; k++) push(w, busy_rec(6'd0, 4'hF));
        for (int k = 0; k < p; k++) push(w, busy_rec(6'b100000, 4'hF));
        for (int k = 0; k < g; k++) push(w, busy_rec(6'd0, 4'hF));
        push(w, idle_rec(1'b0, 1'b1));
    endtask

    // Returns one cycle after the accepting edge, with scrambled inputs applied.
    task automatic start_cmd(input vec_t t, input int nrec, input bit fin);
        @(posedge clk); #1;
        drive(int'(t.w), 1'b1, t.a, t.b, t.op);
        push(int'(t.w), idle_rec(1'b0, 1'b0));
        push_cmd(t, nrec, fin);
        @(posedge clk); #1;
        drive(int'(t.w), 1'b0, ~t.a, ~t.b, ~t.op);
    endtask

    task automatic drain(input int w);
        int n;
        n = 0;
        while (qsize(w) != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check_val("drain", qsize(w), 0);
        if (w == 0) q0.delete();
        else q1.delete();
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; ab0 = 1'b0; ab1 = 1'b0;
        drive(0, 1'b0, 3'd0, 3'd0, 1'b0);
        drive(1, 1'b0, 3'd0, 3'd0, 1'b0);

        tbl[0] = mk(1'b0, 3'b101, 3'b011, 1'b1,
                    KCLR, K1, K0, K1, KXOR, K0, K1, K1, KEQ);
        tbl[1] = mk(1'b1, 3'b000, 3'b111, 1'b0,
                    KCLR, K0, K0, K0, KOR, K1, K1, K1, KEQ);
        tbl[2] = mk(1'b0, 3'b110, 3'b001, 1'b0,
                    KCLR, K1, K1, K0, KOR, K0, K0, K1, KEQ);
        tbl[3] = mk(1'b0, 3'b111, 3'b000, 1'b1,
                    KCLR, K1, K1, K1, KXOR, K0, K0, K0, KEQ);
        tbl[4] = mk(1'b1, 3'b010, 3'b100, 1'b1,
                    KCLR, K0, K1, K0, KXOR, K1, K0, K0, KEQ);

        @(posedge clk); #1;
        mon_en = 1'b1;
        check_val("ready_in_reset0", int'(rdy0), 1);
        check_val("ready_in_reset1", int'(rdy1), 1);
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;

        for (int i = 0; i < 5; i++) begin
            start_cmd(tbl[i], tbl[i].w ? 9 * (P1 + G1) : 9 * (P0 + G0), 1'b1);
            drain(int'(tbl[i].w));
        end

        // back-to-back: second command captured in the done cycle
        @(posedge clk); #1;
        drive(0, 1'b1, tbl[0].a, tbl[0].b, tbl[0].op);
        push(0, idle_rec(1'b0, 1'b0));
        push_cmd(tbl[0], 45, 1'b1);
        push_cmd(tbl[2], 45, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(0, 1'b1, tbl[2].a, tbl[2].b, tbl[2].op);
        repeat (45) @(posedge clk);
        #1;
        drive(0, 1'b0, 3'd0, 3'd0, 1'b0);
        drain(0);

        // abort during slot 4 press, held through the abort sequence
        start_cmd(tbl[0], 21, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        ab0 = 1'b1;
        push_abort(0);
        repeat (10) @(posedge clk);
        #1;
        ab0 = 1'b0;
        drain(0);

        // abort coinciding with completion of slot 8
        start_cmd(tbl[2], 45, 1'b0);
        repeat (44) @(posedge clk);
        #1;
        ab0 = 1'b1;
        push_abort(0);
        @(posedge clk); #1;
        ab0 = 1'b0;
        drain(0);

        // reset during slot 6, then replay from Clear
        start_cmd(tbl[3], 31, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        drain(0);
        start_cmd(tbl[3], 45, 1'b1);
        drain(0);

        // reset wins over cmd_valid and abort
        @(posedge clk); #1;
        rst0 = 1'b1; ab0 = 1'b1;
        drive(0, 1'b1, 3'b111, 3'b111, 1'b1);
        @(posedge clk); #1;
        rst0 = 1'b0; ab0 = 1'b0;
        drive(0, 1'b0, 3'd0, 3'd0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check_val("idle_after_rst_valid", int'(busy0), 0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
        $finish;
    end

endmodule
